// File: rtl/uart_row_packet_rx.sv
// Row packet assembler: unpacks a UART row packet (row index, packed 3-bit pixels,
// end marker) into single-pixel frame RAM writes and answers the host with ACK/NAK.
//
// state  | meaning
// IDLE   | waiting for row high byte; any other byte is dropped (resync)
// ROW_LO | waiting for row low byte
// PIXELS | unpacking pixel bytes, one RAM write per completed pixel
// END    | waiting for the end marker
// ANSWER | holding ACK/NAK until the transmitter takes it

module uart_row_packet_rx #(
  parameter int         WIDTH       = 640,
  parameter int         HEIGHT      = 480,
  parameter int         ADDR_W      = 19,
  parameter logic [7:0] END_CODE    = 8'hFF,
  parameter logic [7:0] ACK_CODE    = 8'hAA,
  parameter logic [7:0] NAK_CODE    = 8'h55,
  parameter int         TIMEOUT_CYC = 2_000_000
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [2:0]        pix_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              frame_done,
  output logic [8:0]        row_out,
  output logic              busy
);

  localparam int ROW_BYTES = 3 * WIDTH / 8;
  localparam int CNT_W     = $clog2(ROW_BYTES + 1);
  localparam int PIX_W     = $clog2(WIDTH + 1);
  localparam int GAP_W     = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, ROW_LO, PIXELS, END, ANSWER} state_t;

  state_t            state, state_nxt;
  logic [8:0]        row, row_nxt;
  logic [ADDR_W-1:0] row_base, row_base_nxt;
  logic              err, err_nxt;
  logic [9:0]        acc, acc_nxt;
  logic [3:0]        acc_n, acc_n_nxt;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
  logic [PIX_W-1:0]  pix_idx, pix_idx_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              pix_we_nxt;
  logic [ADDR_W-1:0] pix_addr_nxt;
  logic [2:0]        pix_data_nxt;
  logic [7:0]        tx_data_nxt;
  logic              tx_valid_nxt;
  logic              frame_done_nxt;
  logic [8:0]        row_out_nxt;
  logic              busy_nxt;

  logic [8:0]        row_full;
  logic [9:0]        acc_in;
  logic [3:0]        acc_in_n;
  logic              in_packet;
  logic              timeout;

  assign row_full  = {row[8], rx_data};
  assign in_packet = (state == ROW_LO) || (state == PIXELS) || (state == END);
  // Gap timer is a down-counter reloaded by every byte; zero means the host went quiet.
  assign timeout   = in_packet && !rx_valid && (gap_cnt == '0);

  always_comb begin
    state_nxt      = state;
    row_nxt        = row;
    row_base_nxt   = row_base;
    err_nxt        = err;
    acc_nxt        = acc;
    acc_n_nxt      = acc_n;
    byte_cnt_nxt   = byte_cnt;
    pix_idx_nxt    = pix_idx;
    gap_cnt_nxt    = gap_cnt;
    pix_we_nxt     = 1'b0;
    pix_addr_nxt   = pix_addr;
    pix_data_nxt   = pix_data;
    tx_data_nxt    = tx_data;
    tx_valid_nxt   = tx_valid;
    frame_done_nxt = 1'b0;
    row_out_nxt    = row_out;
    acc_in         = acc;
    acc_in_n       = acc_n;

    if (rx_valid)
      gap_cnt_nxt = GAP_W'(TIMEOUT_CYC - 1);
    else if (in_packet && gap_cnt != '0)
      gap_cnt_nxt = gap_cnt - GAP_W'(1);

    if (timeout) begin
      state_nxt    = ANSWER;
      tx_valid_nxt = 1'b1;
      tx_data_nxt  = NAK_CODE;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid && rx_data[7:1] == 7'd0) begin
            row_nxt   = {rx_data[0], 8'd0};
            err_nxt   = 1'b0;
            state_nxt = ROW_LO;
          end
        end
        ROW_LO: begin
          if (rx_err) err_nxt = 1'b1;
          if (rx_valid) begin
            row_nxt      = row_full;
            row_base_nxt = ADDR_W'(row_full) * ADDR_W'(WIDTH);
            if (int'(row_full) >= HEIGHT) err_nxt = 1'b1;
            byte_cnt_nxt = '0;
            pix_idx_nxt  = '0;
            acc_nxt      = '0;
            acc_n_nxt    = '0;
            state_nxt    = PIXELS;
          end
        end
        PIXELS: begin
          if (rx_err) err_nxt = 1'b1;
          // The arriving byte is merged before extraction so its first pixel leaves next cycle.
          if (rx_valid) begin
            acc_in       = acc | (10'(rx_data) << acc_n);
            acc_in_n     = acc_n + 4'd8;
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
          end
          acc_nxt   = acc_in;
          acc_n_nxt = acc_in_n;
          if (acc_in_n >= 4'd3) begin
            pix_we_nxt   = !err;
            pix_data_nxt = acc_in[2:0];
            pix_addr_nxt = row_base + ADDR_W'(pix_idx);
            acc_nxt      = acc_in >> 3;
            acc_n_nxt    = acc_in_n - 4'd3;
            pix_idx_nxt  = pix_idx + PIX_W'(1);
          end
          if (byte_cnt_nxt == CNT_W'(ROW_BYTES) && acc_n_nxt == 4'd0)
            state_nxt = END;
        end
        END: begin
          if (rx_valid) begin
            state_nxt    = ANSWER;
            tx_valid_nxt = 1'b1;
            if (rx_data == END_CODE && !err && !rx_err) begin
              tx_data_nxt    = ACK_CODE;
              frame_done_nxt = 1'b1;
              row_out_nxt    = row;
            end else begin
              tx_data_nxt = NAK_CODE;
            end
          end else if (rx_err) begin
            err_nxt = 1'b1;
          end
        end
        ANSWER: begin
          if (tx_valid && tx_ready) begin
            tx_valid_nxt = 1'b0;
            state_nxt    = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      row_base   <= '0;
      err        <= 1'b0;
      acc        <= '0;
      acc_n      <= '0;
      byte_cnt   <= '0;
      pix_idx    <= '0;
      gap_cnt    <= '0;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      frame_done <= 1'b0;
      row_out    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      row_base   <= row_base_nxt;
      err        <= err_nxt;
      acc        <= acc_nxt;
      acc_n      <= acc_n_nxt;
      byte_cnt   <= byte_cnt_nxt;
      pix_idx    <= pix_idx_nxt;
      gap_cnt    <= gap_cnt_nxt;
      pix_we     <= pix_we_nxt;
      pix_addr   <= pix_addr_nxt;
      pix_data   <= pix_data_nxt;
      tx_data    <= tx_data_nxt;
      tx_valid   <= tx_valid_nxt;
      frame_done <= frame_done_nxt;
      row_out    <= row_out_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
